// File: rtl/icache_assoc_if.sv
// AXI4 read-address and read-data channels between the instruction cache and memory.
interface icache_assoc_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    modport master (
        output araddr, arvalid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  araddr, arvalid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with round-robin replacement, whole-line INCR refill,
// critical-word capture during refill, fence.i flush, and uncached bus-error reporting.
module icache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_require,
    input  logic [31:0] pc,
    input  logic        fencei,
    input  logic        ctrl_valid,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic        inst_err,
    icache_assoc_if.master axi
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TB = 30 - OB - IB;
    localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, AR, REFILL, RESP} state_t;

    state_t                       state_reg, state_next;
    logic [31:2]                  pc_reg;
    logic [31:0]                  inst_reg;
    logic                         err_reg;
    logic                         fence_seen_reg;
    logic [WB-1:0]                victim_reg, victim_next;
    logic [OB-1:0]                beat_reg;
    logic [WAYS-1:0][SETS-1:0]    valid_reg;
    logic [SETS-1:0][WB-1:0]      rr_reg;

    logic [IB-1:0]                lk_idx;
    logic [OB-1:0]                lk_off;
    logic [TB-1:0]                lk_tag;
    logic [IB+OB-1:0]             rd_addr;
    logic [WAYS-1:0]              hit_vec;
    logic [WAYS-1:0][31:0]        data_rd_all;
    logic [31:0]                  hit_word;
    logic                         fence_now, beat_fire, last_beat, err_now, fill_commit;
    logic [WB-1:0]                rr_adv;
    wire                          unused_pc_bits = ^pc[1:0];

    assign lk_idx      = pc_reg[OB+2 +: IB];
    assign lk_off      = pc_reg[2 +: OB];
    assign lk_tag      = pc_reg[31 -: TB];
    assign rd_addr     = {pc[OB+2 +: IB], pc[2 +: OB]};
    assign fence_now   = fencei && ctrl_valid;
    assign beat_fire   = (state_reg == REFILL) && axi.rvalid;
    assign last_beat   = axi.rlast || (beat_reg == OB'(LINE_WORDS - 1));
    assign err_now     = err_reg || (axi.rresp != 2'b00);
    // A fence arriving during the burst, or on its final beat, keeps the line invalid.
    assign fill_commit = beat_fire && last_beat && !err_now && !fence_seen_reg && !fence_now;
    assign rr_adv      = (WAYS == 1) ? '0 : victim_reg + 1'b1;

    // Per-way arrays: tag/data are read with a registered port while idle, ready for LOOKUP.
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [31:0]   data_mem [SETS*LINE_WORDS];
            logic [TB-1:0] tag_mem  [SETS];
            logic [31:0]   data_rd_reg;
            logic [TB-1:0] tag_rd_reg;

            always_ff @(posedge clock) begin
                if (beat_fire && victim_reg == WB'(gi))
                    data_mem[{lk_idx, beat_reg}] <= axi.rdata;
                if (fill_commit && victim_reg == WB'(gi))
                    tag_mem[lk_idx] <= lk_tag;
                if (state_reg == IDLE) begin
                    data_rd_reg <= data_mem[rd_addr];
                    tag_rd_reg  <= tag_mem[rd_addr[OB +: IB]];
                end
            end

            assign hit_vec[gi]     = valid_reg[gi][lk_idx] && (tag_rd_reg == lk_tag);
            assign data_rd_all[gi] = data_rd_reg;
        end
    endgenerate

    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WAYS; w++)
            if (hit_vec[w]) hit_word = hit_word | data_rd_all[w];
    end

    // Lowest-index invalid way wins; otherwise the set's round-robin pointer.
    always_comb begin
        victim_next = rr_reg[lk_idx];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_reg[w][lk_idx]) victim_next = WB'(w);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (inst_require) state_next = LOOKUP;
            LOOKUP:  state_next = (|hit_vec) ? RESP : AR;
            AR:      if (axi.arready) state_next = REFILL;
            REFILL:  if (beat_fire && last_beat) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        inst_valid  = (state_reg == RESP);
        inst_err    = (state_reg == RESP) && err_reg;
        inst        = inst_reg;
        axi.arvalid = (state_reg == AR);
    end

    assign axi.araddr  = {pc_reg[31:OB+2], {(OB+2){1'b0}}};
    assign axi.arlen   = 8'(LINE_WORDS - 1);
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.rready  = 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_reg         <= '0;
            inst_reg       <= '0;
            err_reg        <= 1'b0;
            fence_seen_reg <= 1'b0;
            victim_reg     <= '0;
            beat_reg       <= '0;
            valid_reg      <= '0;
            rr_reg         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    err_reg        <= 1'b0;
                    fence_seen_reg <= 1'b0;
                    beat_reg       <= '0;
                    if (inst_require) pc_reg <= pc[31:2];
                end
                LOOKUP: begin
                    if (|hit_vec) inst_reg <= hit_word;
                    victim_reg <= victim_next;
                end
                AR: begin
                    if (fence_now) fence_seen_reg <= 1'b1;
                end
                REFILL: begin
                    if (fence_now) fence_seen_reg <= 1'b1;
                    if (beat_fire) begin
                        beat_reg <= beat_reg + 1'b1;
                        if (axi.rresp != 2'b00) err_reg <= 1'b1;
                        if (beat_reg == lk_off) inst_reg <= axi.rdata;
                        if (last_beat && err_now) inst_reg <= '0;
                    end
                end
                default: ;
            endcase

            if (fence_now)        valid_reg <= '0;
            else if (fill_commit) valid_reg[victim_reg][lk_idx] <= 1'b1;
            if (fill_commit)      rr_reg[lk_idx] <= rr_adv;
        end
    end

    a_single_hit: assert property (@(posedge clock) disable iff (!reset)
        (state_reg == LOOKUP) |-> $onehot0(hit_vec));
    a_rlast_pos: assert property (@(posedge clock) disable iff (!reset)
        (beat_fire && axi.rlast) |-> (beat_reg == OB'(LINE_WORDS - 1)));
    a_no_stray_beat: assert property (@(posedge clock) disable iff (!reset)
        axi.rvalid |-> (state_reg == REFILL));
endmodule

// File: tb/tb_icache_assoc.sv
// Randomised bench for icache_assoc: a per-set valid/tag/round-robin model predicts hit or miss,
// victim choice and response data for every fetch; memory contents are a fixed address function.
module tb_icache_assoc;
    localparam int WAYS = 2;
    localparam int SETS = 4;
    localparam int LW   = 4;
    localparam int OB   = $clog2(LW);
    localparam int IB   = $clog2(SETS);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inst_require = 1'b0;
    logic [31:0] pc = '0;
    logic        fencei = 1'b0;
    logic        ctrl_valid = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_err;

    icache_assoc_if axi();

    icache_assoc #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
        .clock(clock), .reset(reset), .inst_require(inst_require), .pc(pc),
        .fencei(fencei), .ctrl_valid(ctrl_valid), .inst_valid(inst_valid),
        .inst(inst), .inst_err(inst_err), .axi(axi)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    int          m_rr    [SETS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hAAAA, a[31:16]};
    endfunction

    function automatic int model_way(input logic [31:0] a);
        int s = int'((a >> (OB + 2)) % SETS);
        int unsigned t = a >> (OB + 2 + IB);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    task automatic model_clear(input bit with_rr);
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
            if (with_rr) m_rr[s] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        inst_require = 0; fencei = 0; ctrl_valid = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0;
        reset = 0;
        repeat (2) @(posedge clock);
        #2 reset = 1;
        model_clear(1);
    endtask

    task automatic idle_fence(input bit qual);
        fencei = 1; ctrl_valid = qual;
        tick();
        fencei = 0; ctrl_valid = 0;
        if (qual) model_clear(0);
        $display("fence ctrl_valid=%0b", qual);
    endtask

    task automatic fetch(input logic [31:0] a, input int err_beat, input int fence_beat, input bit lk_fence);
        int s, hw, victim;
        int unsigned t;
        logic [31:0] line, wa;
        bit exp_err, fenced, ok;
        s    = int'((a >> (OB + 2)) % SETS);
        t    = a >> (OB + 2 + IB);
        wa   = {a[31:2], 2'b00};
        line = a & ~32'(LW * 4 - 1);
        hw   = model_way(a);

        pc = a; inst_require = 1;
        tick();
        inst_require = 0; pc = $urandom;
        check("lookup_quiet", {30'b0, inst_valid, axi.arvalid}, 32'd0);
        if (lk_fence) begin fencei = 1; ctrl_valid = 1; end
        tick();
        fencei = 0; ctrl_valid = 0;
        if (lk_fence) model_clear(0);

        if (hw >= 0) begin
            check("hit_valid", {31'b0, inst_valid}, 32'd1);
            check("hit_inst", inst, mem_word(wa));
            check("hit_err", {31'b0, inst_err}, 32'd0);
            check("hit_no_ar", {31'b0, axi.arvalid}, 32'd0);
            $display("fetch pc=%h hit way=%0d inst=%h err=%0b", a, hw, inst, inst_err);
            ok = inst_valid;
            tick();
            check("hit_pulse_end", {31'b0, inst_valid}, 32'd0);
            if (!ok) do_reset();
            return;
        end

        check("miss_arvalid", {31'b0, axi.arvalid}, 32'd1);
        if (!axi.arvalid) begin do_reset(); return; end
        check("araddr", axi.araddr, line);
        check("arlen", {24'b0, axi.arlen}, 32'(LW - 1));
        check("ar_const", {26'b0, axi.rready, axi.arburst, axi.arsize}, {26'b0, 1'b1, 2'b01, 3'b010});
        repeat ($urandom_range(0, 3)) begin
            tick();
            check("ar_hold", {31'b0, axi.arvalid}, 32'd1);
            check("ar_stable", axi.araddr, line);
        end
        axi.arready = 1;
        tick();
        axi.arready = 0;
        check("ar_drop", {31'b0, axi.arvalid}, 32'd0);

        victim = m_rr[s];
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) victim = w;
        exp_err = 0; fenced = 0;
        for (int k = 0; k < LW; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            axi.rvalid = 1;
            axi.rdata  = mem_word(line + 32'(4 * k));
            axi.rresp  = (k == err_beat) ? (($urandom % 2) ? 2'b10 : 2'b11) : 2'b00;
            axi.rlast  = (k == LW - 1);
            if (k == err_beat) exp_err = 1;
            if (k == fence_beat) begin fencei = 1; ctrl_valid = 1; fenced = 1; end
            tick();
            axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0; fencei = 0; ctrl_valid = 0;
        end

        check("miss_valid", {31'b0, inst_valid}, 32'd1);
        check("miss_inst", inst, exp_err ? 32'd0 : mem_word(wa));
        check("miss_err", {31'b0, inst_err}, {31'b0, exp_err});
        if (fenced) model_clear(0);
        else if (!exp_err) begin
            m_valid[s][victim] = 1;
            m_tag[s][victim]   = t;
            m_rr[s]            = (victim + 1) % WAYS;
        end
        $display("fetch pc=%h miss victim=%0d inst=%h err=%0b fence=%0b", a, victim, inst, inst_err, fenced);
        ok = inst_valid;
        tick();
        check("miss_pulse_end", {31'b0, inst_valid}, 32'd0);
        if (!ok) do_reset();
    endtask

    task automatic reset_mid(input logic [31:0] a, input bit in_refill);
        idle_fence(1);
        pc = a; inst_require = 1;
        tick();
        inst_require = 0;
        tick();
        check("rst_pre_ar", {31'b0, axi.arvalid}, 32'd1);
        if (in_refill) begin
            axi.arready = 1;
            tick();
            axi.arready = 0;
            axi.rvalid = 1; axi.rdata = mem_word(a); axi.rresp = 0; axi.rlast = 0;
            tick();
            axi.rvalid = 0;
        end
        #2 reset = 0;
        #1;
        check("rst_arvalid", {31'b0, axi.arvalid}, 32'd0);
        check("rst_outputs", {30'b0, inst_valid, inst_err}, 32'd0);
        check("rst_inst", inst, 32'd0);
        repeat (2) @(posedge clock);
        #2 reset = 1;
        model_clear(1);
        $display("reset during %s pc=%h", in_refill ? "REFILL" : "AR", a);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int r, eb, fb;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
        model_clear(1);
        #1 reset = 0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {29'b0, inst_valid, inst_err, axi.arvalid}, 32'd0);
        check("reset_inst", inst, 32'd0);
        #1 reset = 1;

        fetch(32'h8000_0004, -1, -1, 0);
        fetch(32'h8000_0008, -1, -1, 0);
        fetch(32'h8000_0040, -1, -1, 0);
        fetch(32'h8000_0080, -1, -1, 0);
        fetch(32'h8000_0044, -1, -1, 0);
        fetch(32'h8000_0000, -1, -1, 0);
        fetch(32'h8000_0010, 2, -1, 0);
        fetch(32'h8000_0014, -1, -1, 0);
        fetch(32'h8000_0020, -1, 1, 0);
        fetch(32'h8000_0024, -1, -1, 0);
        idle_fence(0);
        fetch(32'h8000_0028, -1, -1, 1);
        fetch(32'h8000_002C, -1, LW - 1, 0);
        fetch(32'h8000_002C, -1, -1, 0);
        reset_mid(32'h8000_0030, 0);
        reset_mid(32'h8000_0034, 1);
        fetch(32'h8000_0014, -1, -1, 0);

        for (int i = 0; i < 220; i++) begin
            r = int'($urandom % 12);
            if (r == 0) idle_fence(1);
            else if (r == 1) idle_fence(0);
            else begin
                a  = 32'h8000_0000 + ($urandom_range(0, 3) << (OB + 2 + IB))
                   + ($urandom_range(0, SETS - 1) << (OB + 2))
                   + ($urandom_range(0, LW - 1) << 2) + $urandom_range(0, 3);
                eb = ($urandom % 8 == 0) ? int'($urandom_range(0, LW - 1)) : -1;
                fb = ($urandom % 10 == 0) ? int'($urandom_range(0, LW - 1)) : -1;
                fetch(a, eb, fb, (model_way(a) >= 0) && ($urandom % 6 == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
